// File: rtl/combo_sweeper_pkg.sv
// Shared types and constants for the combo_sweeper stimulus/capture block.
package combo_sweeper_pkg;

  localparam int COMBO_N_IN   = 5;
  localparam int COMBO_SETTLE = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  function automatic int table_depth(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/combo_sweeper_if.sv
// Control, stimulus and result signals between a sweep controller and its user.
interface combo_sweeper_if
  import combo_sweeper_pkg::*;
#(
  parameter int N_IN = COMBO_N_IN
);
  localparam int DEPTH = table_depth(N_IN);

  // Handshake: start is sampled only while busy=0; an accepted start raises busy the next
  // cycle, done pulses for one cycle when a full sweep ends, abort drops busy without done.
  logic             start;
  logic             abort;
  logic [DEPTH-1:0] exp_table;
  logic             z_in;
  logic [N_IN-1:0]  in_vec;
  logic             busy;
  logic             done;
  logic             pass;
  logic [DEPTH-1:0] truth_table;
  logic [N_IN:0]    mismatch_cnt;
  logic [N_IN-1:0]  first_fail;
  logic             fail_valid;
  state_t           state_dbg;

  modport master (
    output start, abort, exp_table, z_in,
    input  in_vec, busy, done, pass, truth_table, mismatch_cnt, first_fail, fail_valid,
           state_dbg
  );

  modport slave (
    input  start, abort, exp_table, z_in,
    output in_vec, busy, done, pass, truth_table, mismatch_cnt, first_fail, fail_valid,
           state_dbg
  );

endinterface

// File: rtl/combo_sweeper_settle_timer.sv
// Settle-time counter: cleared by load, counts while enabled, flags the last settle cycle.
module combo_sweeper_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [W-1:0] LAST = W'(SETTLE - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/combo_sweeper.sv
// Sweeps every input vector of the combo gate in order, records z, and compares the
// observed truth table with the expected one.
module combo_sweeper
  import combo_sweeper_pkg::*;
#(
  parameter int N_IN   = COMBO_N_IN,
  parameter int SETTLE = COMBO_SETTLE
) (
  input logic            clk,
  input logic            rst_n,
  combo_sweeper_if.slave bus
);
  localparam int DEPTH = table_depth(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  state_t           state;
  logic [N_IN-1:0]  idx;
  logic [DEPTH-1:0] exp_latch;
  logic [N_IN-1:0]  in_vec_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [DEPTH-1:0] truth_table_r;
  logic [N_IN:0]    mismatch_cnt_r;
  logic [N_IN-1:0]  first_fail_r;
  logic             fail_valid_r;

  logic timer_load;
  logic timer_en;
  logic timer_expire;
  logic abort_hit;
  logic sample_miss;

  // The timer restarts whenever a new vector is about to be presented.
  assign timer_load  = (state == ST_IDLE) || (state == ST_SAMPLE);
  assign timer_en    = (state == ST_SETTLE);
  assign abort_hit   = bus.abort && ((state == ST_SETTLE) || (state == ST_SAMPLE));
  assign sample_miss = (bus.z_in != exp_latch[idx]);

  combo_sweeper_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      exp_latch      <= '0;
      in_vec_r       <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      truth_table_r  <= '0;
      mismatch_cnt_r <= '0;
      first_fail_r   <= '0;
      fail_valid_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort_hit) begin
        // Partial results stay visible; pass was cleared at start and remains 0.
        state    <= ST_IDLE;
        busy_r   <= 1'b0;
        in_vec_r <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              exp_latch      <= bus.exp_table;
              truth_table_r  <= '0;
              mismatch_cnt_r <= '0;
              first_fail_r   <= '0;
              fail_valid_r   <= 1'b0;
              pass_r         <= 1'b0;
              idx            <= '0;
              in_vec_r       <= '0;
              busy_r         <= 1'b1;
              state          <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (timer_expire) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            truth_table_r[idx] <= bus.z_in;
            if (sample_miss) begin
              mismatch_cnt_r <= mismatch_cnt_r + 1'b1;
              if (!fail_valid_r) begin
                first_fail_r <= idx;
                fail_valid_r <= 1'b1;
              end
            end
            // Terminal test on idx itself so the index never wraps.
            if (idx == LAST_IDX) begin
              state <= ST_FINISH;
            end else begin
              idx      <= idx + 1'b1;
              in_vec_r <= idx + 1'b1;
              state    <= ST_SETTLE;
            end
          end
          ST_FINISH: begin
            done_r <= 1'b1;
            pass_r <= (mismatch_cnt_r == '0);
            busy_r <= 1'b0;
            state  <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_vec       = in_vec_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.pass         = pass_r;
  assign bus.truth_table  = truth_table_r;
  assign bus.mismatch_cnt = mismatch_cnt_r;
  assign bus.first_fail   = first_fail_r;
  assign bus.fail_valid   = fail_valid_r;
  assign bus.state_dbg    = state;

endmodule

// File: tb/tb_combo_sweeper.sv
// Bench for combo_sweeper: two instances (settle 1 and 3), a cycle-indexed sweep model,
// directed scenarios with literal expectations, then randomized sweeps.
module tb_combo_sweeper;
  import combo_sweeper_pkg::*;

  localparam int N_IN = 5;
  localparam int N    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // ---------------- stimulus and observation ----------------
  logic        start_s[2];
  logic        abort_s[2];
  logic [31:0] exp_s[2];
  int          mode_s[2];
  logic [31:0] ztab_s[2];

  logic        busy_w[2];
  logic        done_w[2];
  logic        pass_w[2];
  logic        fv_w[2];
  logic [4:0]  in_vec_w[2];
  logic [4:0]  ff_w[2];
  logic [5:0]  cnt_w[2];
  logic [31:0] tt_w[2];

  int total = 0;
  int bad   = 0;
  bit checks_on = 1'b0;
  logic [N_IN-1:0] exp_q[$];

  function automatic logic zfun(input int mode, input logic [31:0] tab, input logic [4:0] v);
    case (mode)
      0:       return &v;
      1:       return ^v;
      default: return tab[v];
    endcase
  endfunction

  function automatic int sweep_len(input int d);
    return N * ((d == 0) ? 2 : 4) + 1;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- DUTs and per-instance model ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int SET = (gi == 0) ? 1 : 3;
    localparam int P   = SET + 1;

    combo_sweeper_if #(.N_IN(N_IN)) bus ();
    combo_sweeper #(.N_IN(N_IN), .SETTLE(SET)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.start     = start_s[gi];
    assign bus.abort     = abort_s[gi];
    assign bus.exp_table = exp_s[gi];
    assign bus.z_in      = zfun(mode_s[gi], ztab_s[gi], bus.in_vec);

    assign busy_w[gi]   = bus.busy;
    assign done_w[gi]   = bus.done;
    assign pass_w[gi]   = bus.pass;
    assign fv_w[gi]     = bus.fail_valid;
    assign in_vec_w[gi] = bus.in_vec;
    assign ff_w[gi]     = bus.first_fail;
    assign cnt_w[gi]    = bus.mismatch_cnt;
    assign tt_w[gi]     = bus.truth_table;

    // Model: k counts clock edges since the accepted start; vector v is on in_vec for
    // edges v*P .. v*P+P-1, sampled at edge (v+1)*P, and done appears at edge N*P+1.
    bit          run = 1'b0;
    int          k = 0;
    int          v;
    logic        z;
    logic [31:0] m_exp = '0, m_tt = '0;
    int          m_cnt = 0, m_ff = 0, m_in = 0;
    bit          m_fv = 1'b0, m_pass = 1'b0, m_done = 1'b0, m_busy = 1'b0;

    always @(posedge clk) begin
      m_done = 1'b0;
      if (!rst_n) begin
        run = 1'b0; m_exp = '0; m_tt = '0; m_cnt = 0; m_ff = 0; m_in = 0;
        m_fv = 1'b0; m_pass = 1'b0; m_busy = 1'b0;
      end else if (run) begin
        k++;
        if (abort_s[gi] && k <= N * P) begin
          run = 1'b0; m_busy = 1'b0; m_in = 0;
        end else if (k == N * P + 1) begin
          m_done = 1'b1; m_pass = (m_cnt == 0); m_busy = 1'b0; run = 1'b0;
        end else begin
          if (k % P == 0) begin
            v = k / P - 1;
            z = zfun(mode_s[gi], ztab_s[gi], v[4:0]);
            m_tt[v] = z;
            if (z !== m_exp[v]) begin
              m_cnt++;
              if (!m_fv) begin m_ff = v; m_fv = 1'b1; end
            end
          end
          m_in = (k / P > N - 1) ? N - 1 : k / P;
        end
      end else if (start_s[gi] && !abort_s[gi]) begin
        run = 1'b1; k = 0; m_tt = '0; m_cnt = 0; m_ff = 0; m_fv = 1'b0; m_pass = 1'b0;
        m_exp = exp_s[gi]; m_busy = 1'b1; m_in = 0;
      end
    end

    always @(negedge clk) begin
      if (checks_on) begin
        check($sformatf("d%0d busy", gi),   bus.busy,         m_busy);
        check($sformatf("d%0d done", gi),   bus.done,         m_done);
        check($sformatf("d%0d pass", gi),   bus.pass,         m_pass);
        check($sformatf("d%0d in_vec", gi), bus.in_vec,       m_in);
        check($sformatf("d%0d table", gi),  bus.truth_table,  m_tt);
        check($sformatf("d%0d mcnt", gi),   bus.mismatch_cnt, m_cnt);
        check($sformatf("d%0d ffail", gi),  bus.first_fail,   m_ff);
        check($sformatf("d%0d fvalid", gi), bus.fail_valid,   m_fv);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns #1 after the edge that accepts start (edge 0 of the sweep).
  task automatic start_sweep(input int d, input int mode, input logic [31:0] tab,
                             input logic [31:0] exp);
    @(posedge clk); #1;
    mode_s[d] = mode; ztab_s[d] = tab; exp_s[d] = exp; start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
  endtask

  // Counts edges from 'already' until done is seen; checks in_vec against exp_q if filled.
  task automatic wait_done(input int d, input int already, output int lat);
    lat = already;
    if (exp_q.size() > 0) check("vec_seq", in_vec_w[d], exp_q.pop_front());
    while (lat < 400) begin
      @(posedge clk); lat++; #1;
      if (exp_q.size() > 0) check("vec_seq", in_vec_w[d], exp_q.pop_front());
      if (done_w[d]) break;
    end
    if (!done_w[d]) check("done_timeout", 0, 1);
  endtask

  task automatic check_zero(input string name, input int d);
    check({name, "_busy"}, busy_w[d], 0);
    check({name, "_pass"}, pass_w[d], 0);
    check({name, "_vec"},  in_vec_w[d], 0);
    check({name, "_tt"},   tt_w[d], 0);
    check({name, "_cnt"},  cnt_w[d], 0);
    check({name, "_ff"},   ff_w[d], 0);
    check({name, "_fv"},   fv_w[d], 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, dones, ka, d, mode, choice;
    logic [31:0] tab, tt, exp;

    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; exp_s[i] = '0; mode_s[i] = 0; ztab_s[i] = '0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_zero("reset", 0);
    check_zero("reset1", 1);

    // AND gate, matching expectation.
    start_sweep(0, 0, '0, 32'h8000_0000);
    wait_done(0, 0, lat);
    check("t1_latency", lat, 65);
    check("t1_pass", pass_w[0], 1);
    check("t1_tt", tt_w[0], 32'h8000_0000);
    check("t1_cnt", cnt_w[0], 0);
    check("t1_fv", fv_w[0], 0);

    // AND gate against an all-zero expectation.
    start_sweep(0, 0, '0, 32'h0);
    wait_done(0, 0, lat);
    check("t2_pass", pass_w[0], 0);
    check("t2_cnt", cnt_w[0], 1);
    check("t2_ff", ff_w[0], 31);
    check("t2_fv", fv_w[0], 1);

    // XOR gate, matching and fully inverted expectations.
    start_sweep(0, 1, '0, 32'h9669_6996);
    wait_done(0, 0, lat);
    check("t3_pass", pass_w[0], 1);
    start_sweep(0, 1, '0, ~32'h9669_6996);
    wait_done(0, 0, lat);
    check("t3_cnt", cnt_w[0], 32);
    check("t3_ff", ff_w[0], 0);
    check("t3_pass_inv", pass_w[0], 0);

    // Abort at edge 20: no done afterwards.
    start_sweep(0, 0, '0, 32'h8000_0000);
    repeat (19) @(posedge clk);
    #1 abort_s[0] = 1'b1;
    @(posedge clk); #1 abort_s[0] = 1'b0;
    check("t4_abort_busy", busy_w[0], 0);
    check("t4_abort_vec", in_vec_w[0], 0);
    dones = 0;
    repeat (80) begin @(posedge clk); #1; if (done_w[0]) dones++; end
    check("t4_no_done", dones, 0);

    // Start pulsed while busy is ignored.
    start_sweep(0, 0, '0, 32'h8000_0000);
    repeat (9) @(posedge clk);
    #1 start_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0;
    wait_done(0, 10, lat);
    check("t4_glitch_latency", lat, 65);

    // Start and abort together while idle: abort wins.
    @(posedge clk); #1 start_s[0] = 1'b1; abort_s[0] = 1'b1;
    @(posedge clk); #1 start_s[0] = 1'b0; abort_s[0] = 1'b0;
    check("t4_start_abort_busy", busy_w[0], 0);

    // Reset mid-sweep at edge 30, then a full sweep.
    start_sweep(0, 1, '0, 32'h0);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check_zero("t5_reset", 0);
    start_sweep(0, 0, '0, 32'h8000_0000);
    wait_done(0, 0, lat);
    check("t5_latency", lat, 65);

    // Settle of 3: each vector held 4 clocks.
    for (int kk = 0; kk < 129; kk++) exp_q.push_back(N_IN'((kk / 4 > 31) ? 31 : kk / 4));
    start_sweep(1, 0, '0, 32'h8000_0000);
    wait_done(1, 0, lat);
    check("t6_latency", lat, 129);
    check("t6_pass", pass_w[1], 1);
    exp_q.delete();

    // Randomized sweeps.
    for (int it = 0; it < 12; it++) begin
      d = $urandom_range(0, 1);
      mode = $urandom_range(0, 2);
      tab = $urandom;
      tt = '0;
      for (int vv = 0; vv < N; vv++) tt[vv] = zfun(mode, tab, 5'(vv));
      choice = $urandom_range(0, 2);
      exp = (choice == 0) ? tt : (choice == 1) ? (tt ^ (32'h1 << $urandom_range(0, 31)))
                                               : 32'($urandom);
      start_sweep(d, mode, tab, exp);
      case ($urandom_range(0, 2))
        0: begin
          ka = $urandom_range(1, sweep_len(d));
          repeat (ka - 1) @(posedge clk);
          #1 abort_s[d] = 1'b1;
          @(posedge clk); #1 abort_s[d] = 1'b0;
          for (int w = 0; w < 300 && busy_w[d]; w++) begin @(posedge clk); #1; end
          repeat (3) @(posedge clk);
        end
        1: begin
          ka = $urandom_range(1, sweep_len(d) - 2);
          repeat (ka - 1) @(posedge clk);
          #1 start_s[d] = 1'b1;
          @(posedge clk); #1 start_s[d] = 1'b0;
          wait_done(d, ka, lat);
          check("rnd_glitch_latency", lat, sweep_len(d));
        end
        default: begin
          wait_done(d, 0, lat);
          check("rnd_latency", lat, sweep_len(d));
          check("rnd_pass", pass_w[d], exp == tt);
        end
      endcase
    end

    repeat (2) @(posedge clk);
    #1 checks_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
